// File: rtl/ysyx_25040109_mem_arbiter.sv
// Round-robin arbiter that shares one downstream memory port between the IFU (reads)
// and the LSU (reads and writes), keeping at most one transaction in flight.
module ysyx_25040109_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,

    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,

    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,

    output logic [ADDR_W-1:0]   mem_araddr,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rvalid,
    output logic                mem_rready,

    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic                mem_wvalid,
    input  logic                mem_wready,

    output logic                err_timeout
);

    localparam int WDOG_W = $clog2(TMO_CYC + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TMO_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IFU_AR,
        S_IFU_R,
        S_LSU_AR,
        S_LSU_R,
        S_LSU_W
    } state_e;

    state_e              state_q, state_d;
    logic                last_lsu_q, last_lsu_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                aw_done_q, aw_done_d;
    logic                err_timeout_q, err_timeout_d;

    logic                ifu_req;
    logic                lsu_req;
    logic                lsu_wr_req;
    logic                ar_hs;
    logic                r_hs;
    logic                aw_hs;
    logic                w_hs;

    // Downstream channels are steered purely by the current grant; everything is 0 in IDLE.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        mem_araddr  = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        mem_awaddr  = '0;
        mem_awvalid = 1'b0;
        mem_wdata   = '0;
        mem_wmask   = '0;
        mem_wvalid  = 1'b0;
        case (state_q)
            S_IFU_AR: begin
                mem_araddr  = ifu_araddr;
                mem_arvalid = ifu_arvalid;
                ifu_arready = mem_arready;
            end
            S_IFU_R: begin
                ifu_rdata  = mem_rdata;
                ifu_rvalid = mem_rvalid;
                mem_rready = ifu_rready;
            end
            S_LSU_AR: begin
                mem_araddr  = lsu_araddr;
                mem_arvalid = lsu_arvalid;
                lsu_arready = mem_arready;
            end
            S_LSU_R: begin
                lsu_rdata  = mem_rdata;
                lsu_rvalid = mem_rvalid;
                mem_rready = lsu_rready;
            end
            S_LSU_W: begin
                // Once the address has been taken it must not be offered a second time.
                mem_awaddr  = lsu_awaddr;
                mem_awvalid = lsu_awvalid & ~aw_done_q;
                lsu_awready = mem_awready & ~aw_done_q;
                mem_wdata   = lsu_wdata;
                mem_wmask   = lsu_wmask;
                mem_wvalid  = lsu_wvalid;
                lsu_wready  = mem_wready;
            end
            default: ;
        endcase
    end

    assign ifu_req     = ifu_arvalid;
    assign lsu_wr_req  = lsu_awvalid | lsu_wvalid;
    assign lsu_req     = lsu_wr_req | lsu_arvalid;
    assign ar_hs       = mem_arvalid & mem_arready;
    assign r_hs        = mem_rvalid & mem_rready;
    assign aw_hs       = mem_awvalid & mem_awready;
    assign w_hs        = mem_wvalid & mem_wready;
    assign err_timeout = err_timeout_q;

    // Next-state: grant in IDLE, advance on handshakes, and let the watchdog abort stalls.
    always_comb begin
        state_d       = state_q;
        last_lsu_d    = last_lsu_q;
        wdog_d        = wdog_q;
        aw_done_d     = aw_done_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (ifu_req && (!lsu_req || last_lsu_q)) begin
                    state_d    = S_IFU_AR;
                    last_lsu_d = 1'b0;
                end else if (lsu_req) begin
                    state_d    = lsu_wr_req ? S_LSU_W : S_LSU_AR;
                    last_lsu_d = 1'b1;
                end
            end
            S_IFU_AR: if (ar_hs) state_d = S_IFU_R;
            S_IFU_R:  if (r_hs)  state_d = S_IDLE;
            S_LSU_AR: if (ar_hs) state_d = S_LSU_R;
            S_LSU_R:  if (r_hs)  state_d = S_IDLE;
            S_LSU_W: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The watchdog measures time spent without progress in the current state.
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (state_q != S_IDLE) begin
            if (wdog_q != WDOG_MAX) wdog_d = wdog_q + WDOG_W'(1);
            if (wdog_d == WDOG_MAX) begin
                err_timeout_d = 1'b1;
                state_d       = S_IDLE;
                wdog_d        = '0;
            end
        end

        if (state_d != S_LSU_W) aw_done_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_lsu_q    <= 1'b1;
            wdog_q        <= '0;
            aw_done_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_lsu_q    <= last_lsu_d;
            wdog_q        <= wdog_d;
            aw_done_q     <= aw_done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

endmodule
